// File: rtl/br_pkg.sv
// Shared branch-unit definitions: opcode encoding, BHT reset value and
// small helpers used by the resolver and its history table.
package br_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BEQ     = 3'd1,
    BNE     = 3'd2,
    BLEZ    = 3'd3,
    BGTZ    = 3'd4,
    BLTZ    = 3'd5,
    BGEZ    = 3'd6,
    BGEZAL  = 3'd7
  } brOpE;

  localparam logic [1:0] BHT_INIT = 2'b01;

  // Next value of a 2-bit saturating counter.
  function automatic logic [1:0] satStep(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  // A source register can not yet be supplied: E will write it, or M is a load.
  function automatic logic srcHazard(input logic [4:0] src,
                                     input logic       regwriteE,
                                     input logic [4:0] dstE,
                                     input logic       regwriteM,
                                     input logic       memtoregM,
                                     input logic [4:0] dstM);
    return (src != 5'd0) &&
           ((regwriteE && dstE == src) || (regwriteM && memtoregM && dstM == src));
  endfunction

endpackage

// File: rtl/bht_counters.sv
// Branch history table of 2-bit saturating counters: combinational read,
// synchronous update, synchronous active-low reset to weakly not-taken.
module bht_counters
  import br_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [1:0]       rdCtr,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrTaken
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [1:0] table_q [DEPTH];

  // Read sees the pre-update value when indices collide in one cycle.
  assign rdCtr = table_q[rdIdx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= BHT_INIT;
    end else if (wrEn) begin
      table_q[wrIdx] <= satStep(table_q[wrIdx], wrTaken);
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// D-stage branch resolver for the 5-stage MIPS pipeline with M/W operand
// forwarding, hazard stall, BHT prediction/update and performance counters.
module branch_resolve_bht
  import br_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_f,
  output logic              pred_taken_f,
  input  logic              valid_d,
  input  logic [2:0]        br_op_d,
  input  logic              pred_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] target_d,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [4:0]        dst_e,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [4:0]        dst_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic              regwrite_w,
  input  logic [4:0]        dst_w,
  input  logic [DATA_W-1:0] wdata_w,
  output logic              stall_d,
  output logic              taken_d,
  output logic              mispredict_d,
  output logic [DATA_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  miss_count
);

  brOpE              brOp;
  logic              active;
  logic              usesRt;
  logic              resolve;
  logic              cond;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [1:0]        rdCtr;

  // E-stage loads stall like any E write, so memtoreg_e carries no extra meaning.
  logic unusedBits;
  assign unusedBits = ^{pc_f[DATA_W-1:IDX_W+2], pc_f[1:0],
                        pc_d[DATA_W-1:IDX_W+2], pc_d[1:0], memtoreg_e};

  assign brOp   = brOpE'(br_op_d);
  assign active = valid_d && (brOp != BR_NONE);
  assign usesRt = (brOp == BEQ) || (brOp == BNE);

  always_comb begin
    opA = rdata1;
    if (regwrite_m && !memtoreg_m && dst_m == rs_d && rs_d != 5'd0)
      opA = alu_result_m;
    else if (regwrite_w && dst_w == rs_d && rs_d != 5'd0)
      opA = wdata_w;
  end

  always_comb begin
    opB = rdata2;
    if (regwrite_m && !memtoreg_m && dst_m == rt_d && rt_d != 5'd0)
      opB = alu_result_m;
    else if (regwrite_w && dst_w == rt_d && rt_d != 5'd0)
      opB = wdata_w;
  end

  assign stall_d = active &&
                   (srcHazard(rs_d, regwrite_e, dst_e, regwrite_m, memtoreg_m, dst_m) ||
                    (usesRt &&
                     srcHazard(rt_d, regwrite_e, dst_e, regwrite_m, memtoreg_m, dst_m)));
  assign resolve = active && !stall_d;

  always_comb begin
    cond = 1'b0;
    case (brOp)
      BEQ:          cond = (opA == opB);
      BNE:          cond = (opA != opB);
      BLEZ:         cond = ($signed(opA) <= 0);
      BGTZ:         cond = ($signed(opA) > 0);
      BLTZ:         cond = ($signed(opA) < 0);
      BGEZ, BGEZAL: cond = ($signed(opA) >= 0);
      default:      cond = 1'b0;
    endcase
  end

  always_comb begin
    taken_d      = 1'b0;
    mispredict_d = 1'b0;
    redirect_pc  = '0;
    if (resolve) begin
      taken_d      = cond;
      mispredict_d = (cond != pred_d);
      redirect_pc  = cond ? target_d : pc_d + DATA_W'(4);
    end
  end

  bht_counters #(.IDX_W(IDX_W)) uBht (
    .clk     (clk),
    .reset   (reset),
    .rdIdx   (pc_f[IDX_W+1:2]),
    .rdCtr   (rdCtr),
    .wrEn    (resolve),
    .wrIdx   (pc_d[IDX_W+1:2]),
    .wrTaken (taken_d)
  );

  assign pred_taken_f = rdCtr[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (resolve && br_count != '1)        br_count   <= br_count + CNT_W'(1);
      if (mispredict_d && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule
